// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command, ALU-drive and response signals of the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int DST_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [4:0]       cmd_op;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [DST_W-1:0] cmd_dst;
    logic             alu_enable;
    logic [4:0]       alu_operation;
    logic [15:0]      alu_in1;
    logic [15:0]      alu_in2;
    logic [15:0]      alu_data_out;
    logic [3:0]       alu_flags;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_data;
    logic [3:0]       rsp_flags;
    logic [DST_W-1:0] rsp_dst;
    logic             rsp_wen;
    logic             rsp_err;
    logic [3:0]       flags_q;
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dst, alu_data_out, alu_flags, rsp_ready,
        output cmd_ready, alu_enable, alu_operation, alu_in1, alu_in2,
               rsp_valid, rsp_data, rsp_flags, rsp_dst, rsp_wen, rsp_err, flags_q
    );
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_dst, alu_data_out, alu_flags, rsp_ready,
        input  cmd_ready, alu_enable, alu_operation, alu_in1, alu_in2,
               rsp_valid, rsp_data, rsp_flags, rsp_dst, rsp_wen, rsp_err, flags_q
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one op at a time through the edge-fired ALU, owns the flag register.
// Macro ALU_ISSUE_FLAG_FIXUP_EN: recompute flags of pow/log2/log10/sqrt/exp from their result.
module alu_issue_ctrl #(
    parameter int SETTLE_CYCLES      = 1,
    parameter int LONG_SETTLE_CYCLES = 4,
    parameter int DST_W              = 3
) (
    input logic             clk,
    input logic             rst_n,
    alu_issue_ctrl_if.slave bus
);
    localparam int MAX_SETTLE = SETTLE_CYCLES > LONG_SETTLE_CYCLES ? SETTLE_CYCLES : LONG_SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_SETTLE + 1);
`ifdef ALU_ISSUE_FLAG_FIXUP_EN
    localparam bit FIXUP = 1'b1;
`else
    localparam bit FIXUP = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} state_t;
    state_t           state;
    logic [4:0]       op;
    logic [15:0]      a;
    logic [15:0]      b;
    logic [DST_W-1:0] dst;
    logic [CNT_W-1:0] cnt;
    logic             ready;
    logic             enable;
    logic             valid;
    logic             wen;
    logic             err;
    logic [15:0]      data;
    logic [3:0]       flags;
    logic             is_err;
    logic             is_long;
    logic             is_cmp;
    logic             is_pass;
    logic [3:0]       cap_flags;

    always_comb begin
        is_err    = op == 5'b00000 || op[4:3] == 2'b11 || ((op == 5'b01000 || op == 5'b01001) && b == 16'd0);
        is_long   = op >= 5'b10011 && op <= 5'b10111;
        is_cmp    = op == 5'b10010;
        is_pass   = op == 5'b10000 || op == 5'b10001;
        // long ops report flags of the ALU's previous result, so the fixup derives them locally
        cap_flags = is_pass ? flags
                  : (FIXUP && is_long) ? {bus.alu_data_out == 16'd0, bus.alu_data_out[15], 2'b00}
                  : bus.alu_flags;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            dst    <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            enable <= 1'b0;
            valid  <= 1'b0;
            wen    <= 1'b0;
            err    <= 1'b0;
            data   <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && ready) begin
                        op    <= bus.cmd_op;
                        a     <= bus.cmd_a;
                        b     <= bus.cmd_b;
                        dst   <= bus.cmd_dst;
                        ready <= 1'b0;
                        state <= SETUP;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (is_err) begin
                        data  <= '0;
                        wen   <= 1'b0;
                        err   <= 1'b1;
                        valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        enable <= ~enable;
                        cnt    <= CNT_W'(is_long ? LONG_SETTLE_CYCLES : SETTLE_CYCLES);
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        data  <= is_cmp ? 16'd0 : bus.alu_data_out;
                        wen   <= !is_cmp;
                        err   <= 1'b0;
                        flags <= cap_flags;
                        valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid <= 1'b0;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = ready;
    assign bus.alu_enable    = enable;
    assign bus.alu_operation = op;
    assign bus.alu_in1       = a;
    assign bus.alu_in2       = b;
    assign bus.rsp_valid     = valid;
    assign bus.rsp_data      = data;
    assign bus.rsp_flags     = flags;
    assign bus.rsp_dst       = dst;
    assign bus.rsp_wen       = wen;
    assign bus.rsp_err       = err;
    assign bus.flags_q       = flags;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl against a transaction-level model.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    int         checks = 0;
    int         errors = 0;
    int         en_edges = 0;
    logic [3:0] ref_flags;
    logic [3:0] long_flags;

    alu_issue_ctrl_if #(.DST_W(3)) bus ();

    alu_issue_ctrl #(.SETTLE_CYCLES(1), .LONG_SETTLE_CYCLES(4), .DST_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_res(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            5'd1:    return a + b;
            5'd16:   return a;
            5'd17:   return b;
            5'd18:   return a - b;
            default: return (a * ({11'd0, op} + 16'd1)) ^ b;
        endcase
    endfunction

    function automatic logic [3:0] alu_flg(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                           input logic [3:0] lf);
        logic [16:0] s;
        logic [15:0] r;
        r = alu_res(op, a, b);
        if (op == 5'd1) begin
            s = {1'b0, a} + {1'b0, b};
            return {r == 16'd0, r[15], s[16], (a[15] == b[15]) && (r[15] != a[15])};
        end
        if (op == 5'd18) return {r == 16'd0, r[15], a < b, (a[15] != b[15]) && (r[15] != a[15])};
        if (op >= 5'd19 && op <= 5'd23) return lf;
        return {r == 16'd0, r[15], a[0] ^ b[0], op[0]};
    endfunction

    // ALU model: every enable edge evaluates the presented operands
    always @(bus.alu_enable) begin
        en_edges++;
        bus.alu_data_out = alu_res(bus.alu_operation, bus.alu_in1, bus.alu_in2);
        bus.alu_flags    = alu_flg(bus.alu_operation, bus.alu_in1, bus.alu_in2, long_flags);
    end

    task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] dst, input int bp, input string tag);
        logic        err_e, long_e, cmp_e, pass_e, wen_e;
        logic [15:0] r, data_e;
        logic [3:0]  f, flags_e;
        int          lat_e, lat, e0;
        err_e  = op == 5'd0 || op >= 5'd24 || ((op == 5'd8 || op == 5'd9) && b == 16'd0);
        long_e = op >= 5'd19 && op <= 5'd23;
        cmp_e  = op == 5'd18;
        pass_e = op == 5'd16 || op == 5'd17;
        r = alu_res(op, a, b);
        f = alu_flg(op, a, b, long_flags);
`ifdef ALU_ISSUE_FLAG_FIXUP_EN
        if (long_e) f = {r == 16'd0, r[15], 2'b00};
`endif
        lat_e   = err_e ? 1 : 2 + (long_e ? 4 : 1);
        data_e  = (err_e || cmp_e) ? 16'd0 : r;
        wen_e   = !err_e && !cmp_e;
        flags_e = (err_e || pass_e) ? ref_flags : f;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL %s cmd_ready_idle: got %b expected 1", tag, bus.cmd_ready); end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_dst   = dst;
        e0 = en_edges;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 5'($urandom);
        bus.cmd_a     = 16'($urandom);
        bus.cmd_b     = 16'($urandom);
        bus.cmd_dst   = 3'($urandom);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != lat_e) begin errors++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, lat_e); end
        checks++; if (bus.rsp_data !== data_e) begin errors++; $display("FAIL %s rsp_data: got %h expected %h", tag, bus.rsp_data, data_e); end
        checks++; if (bus.rsp_flags !== flags_e) begin errors++; $display("FAIL %s rsp_flags: got %b expected %b", tag, bus.rsp_flags, flags_e); end
        checks++; if (bus.flags_q !== flags_e) begin errors++; $display("FAIL %s flags_q: got %b expected %b", tag, bus.flags_q, flags_e); end
        checks++; if (bus.rsp_wen !== wen_e) begin errors++; $display("FAIL %s rsp_wen: got %b expected %b", tag, bus.rsp_wen, wen_e); end
        checks++; if (bus.rsp_err !== err_e) begin errors++; $display("FAIL %s rsp_err: got %b expected %b", tag, bus.rsp_err, err_e); end
        checks++; if (bus.rsp_dst !== dst) begin errors++; $display("FAIL %s rsp_dst: got %h expected %h", tag, bus.rsp_dst, dst); end
        checks++; if ({bus.alu_operation, bus.alu_in1, bus.alu_in2} !== {op, a, b}) begin errors++; $display("FAIL %s alu_inputs: got %h/%h/%h expected %h/%h/%h", tag, bus.alu_operation, bus.alu_in1, bus.alu_in2, op, a, b); end
        checks++; if (en_edges - e0 != (err_e ? 0 : 1)) begin errors++; $display("FAIL %s enable_edges: got %0d expected %0d", tag, en_edges - e0, err_e ? 0 : 1); end
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            checks++; if ({bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags, bus.rsp_wen, bus.rsp_err, bus.rsp_dst} !== {2'b10, data_e, flags_e, wen_e, err_e, dst}) begin errors++; $display("FAIL %s hold_%0d: got v%b r%b %h %b %b %b %h expected stable response", tag, i, bus.rsp_valid, bus.cmd_ready, bus.rsp_data, bus.rsp_flags, bus.rsp_wen, bus.rsp_err, bus.rsp_dst); end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin errors++; $display("FAIL %s post_handshake: got valid %b ready %b expected 0 1", tag, bus.rsp_valid, bus.cmd_ready); end
        ref_flags = flags_e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.alu_enable, bus.flags_q} !== 7'd0) begin errors++; $display("FAIL reset_ctrl: got ready %b valid %b en %b flags %b expected zeros", bus.cmd_ready, bus.rsp_valid, bus.alu_enable, bus.flags_q); end
        checks++; if ({bus.alu_operation, bus.alu_in1, bus.alu_in2} !== 37'd0) begin errors++; $display("FAIL reset_alu: got %h/%h/%h expected zeros", bus.alu_operation, bus.alu_in1, bus.alu_in2); end
        checks++; if ({bus.rsp_data, bus.rsp_flags, bus.rsp_dst, bus.rsp_wen, bus.rsp_err} !== 25'd0) begin errors++; $display("FAIL reset_rsp: got %h %b %h %b %b expected zeros", bus.rsp_data, bus.rsp_flags, bus.rsp_dst, bus.rsp_wen, bus.rsp_err); end
        rst_n = 1'b1;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_release_ready_early: got %b expected 0", bus.cmd_ready); end
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.cmd_ready); end
        ref_flags = 4'd0;
    endtask

    task automatic test_add_overflow();
        run_op(5'd1, 16'h7FFF, 16'h0001, 3'd2, 0, "add_overflow");
    endtask

    task automatic test_cmp_equal();
        run_op(5'd18, 16'd5, 16'd5, 3'd3, 0, "cmp_equal");
    endtask

    task automatic test_div_by_zero();
        run_op(5'd1, 16'h8000, 16'h0000, 3'd1, 0, "div_setup_add");
        run_op(5'd8, 16'd10, 16'd0, 3'd4, 0, "div_by_zero");
    endtask

    task automatic test_sqrt_fixup();
        long_flags = 4'b0110;
        run_op(5'd22, 16'd0, 16'd0, 3'd5, 0, "sqrt_zero");
        run_op(5'd22, 16'h9123, 16'd0, 3'd6, 1, "sqrt_neg");
    endtask

    task automatic test_backpressure();
        run_op(5'd3, 16'h1234, 16'h00F0, 3'd7, 5, "backpressure");
        run_op(5'd16, 16'hBEEF, 16'h0000, 3'd0, 5, "pass_backpressure");
    endtask

    task automatic test_back_to_back();
        run_op(5'd17, 16'h0000, 16'h8001, 3'd1, 0, "b2b_pass");
        run_op(5'd20, 16'h0003, 16'h0002, 3'd2, 0, "b2b_long");
        run_op(5'd31, 16'h0003, 16'h0002, 3'd3, 0, "b2b_bad_op");
        run_op(5'd9, 16'h0007, 16'h0000, 3'd4, 0, "b2b_mod_zero");
        run_op(5'd9, 16'h0007, 16'h0003, 3'd5, 0, "b2b_mod");
        run_op(5'd0, 16'h0007, 16'h0003, 3'd6, 0, "b2b_op0");
    endtask

    task automatic test_reset_mid_wait();
        int seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 5'd20;
        bus.cmd_a     = 16'h0101;
        bus.cmd_b     = 16'h0202;
        bus.cmd_dst   = 3'd5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({bus.cmd_ready, bus.rsp_valid, bus.alu_enable, bus.flags_q} !== 7'd0) begin errors++; $display("FAIL midwait_ctrl: got ready %b valid %b en %b flags %b expected zeros", bus.cmd_ready, bus.rsp_valid, bus.alu_enable, bus.flags_q); end
        checks++; if ({bus.alu_operation, bus.alu_in1, bus.alu_in2, bus.rsp_data, bus.rsp_dst} !== 56'd0) begin errors++; $display("FAIL midwait_data: got %h/%h/%h %h %h expected zeros", bus.alu_operation, bus.alu_in1, bus.alu_in2, bus.rsp_data, bus.rsp_dst); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midwait_ready: got %b expected 1", bus.cmd_ready); end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midwait_no_rsp: got %0d valid cycles expected 0", seen); end
        ref_flags = 4'd0;
    endtask

    task automatic test_random();
        logic [4:0]  op;
        logic [15:0] b;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            long_flags = 4'($urandom);
            run_op(op, 16'($urandom), b, 3'($urandom), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_dst   = '0;
        bus.rsp_ready = 1'b0;
        ref_flags     = '0;
        long_flags    = '0;
        test_reset();
        test_add_overflow();
        test_cmp_equal();
        test_div_by_zero();
        test_sqrt_fixup();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
